coin_field_drawer: RTL and testbench

Successor to the no-points board path. It owns a parametrised ROWS x COLS grid of collectible coins on the 160x120 board. On start it streams every coin's pixels to the VGA plot interface. It then watches player position updates, erases any coin the player lands on, and keeps score. Its plot outputs are arbitrated with the main game datapath's plot stream upstream of vga_adapter.

---
 rtl/coin_field_drawer_if.sv | 28 ++
 rtl/coin_field_drawer.sv | 177 +++++++++++++++++
 tb/tb_coin_field_drawer.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/coin_field_drawer_if.sv
// Plot stream, player update and status signals of the coin field drawer.
// master drives start/player inputs; slave is the drawer itself.
interface coin_field_drawer_if #(
  parameter int SCORE_W = 8
);
  logic               start;
  logic [7:0]         playerX;
  logic [6:0]         playerY;
  logic               playerValid;
  logic [7:0]         oX;
  logic [6:0]         oY;
  logic [8:0]         oColour;
  logic               oPlot;
  logic               busy;
  logic               coin_taken;
  logic [SCORE_W-1:0] score;
  logic               all_collected;

  modport master (
    output start, playerX, playerY, playerValid,
    input  oX, oY, oColour, oPlot, busy, coin_taken, score, all_collected
  );

  modport slave (
    input  start, playerX, playerY, playerValid,
    output oX, oY, oColour, oPlot, busy, coin_taken, score, all_collected
  );
endinterface

// File: rtl/coin_field_drawer.sv
// Grid of collectible coins: draws the field on start, then erases and scores
// each coin the player lands on. One plotted pixel per cycle, no stalls.
//
// state | meaning
// IDLE  | nothing armed, waiting for start
// DRAW  | streaming every coin's pixels in coin colour
// ARMED | field drawn, waiting for a player update or a restart
// CHECK | scanning coins one per cycle against the latched position
// ERASE | plotting the collected coin in background colour
module coin_field_drawer #(
  parameter int         COLS        = 8,
  parameter int         ROWS        = 6,
  parameter int         X0          = 8,
  parameter int         Y0          = 8,
  parameter int         PITCH       = 18,
  parameter int         COIN_SIZE   = 2,
  parameter logic [8:0] COIN_COLOUR = 9'b111111000,
  parameter logic [8:0] BG_COLOUR   = 9'b000000000,
  parameter int         SCORE_W     = 8
) (
  input  logic clock,
  input  logic resetn,
  coin_field_drawer_if.slave bus
);
  localparam int N  = ROWS * COLS;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int OW = (COIN_SIZE > 1) ? $clog2(COIN_SIZE) : 1;

  typedef enum logic [2:0] {IDLE, DRAW, ARMED, CHECK, ERASE} state_t;
  state_t state, state_nxt;

  logic [IW-1:0]      idx;
  logic [CW-1:0]      col;
  logic [7:0]         cx;
  logic [6:0]         cy;
  logic [OW-1:0]      ox, oy;
  logic [N-1:0]       mask;
  logic [7:0]         plx;
  logic [6:0]         ply;
  logic [7:0]         plot_x;
  logic [6:0]         plot_y;
  logic [8:0]         plot_colour;
  logic               plot_en;
  logic               taken;
  logic [SCORE_W-1:0] score_q;
  logic               all_done;

  logic          pix_last, coin_last, hit, start_ok, move_ok;
  logic [OW-1:0] ox_n, oy_n;
  logic [CW-1:0] col_n;
  logic [7:0]    cx_n;
  logic [6:0]    cy_n;
  logic [N-1:0]  mask_after;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pix_last  = (ox == OW'(COIN_SIZE - 1)) && (oy == OW'(COIN_SIZE - 1));
    coin_last = (idx == IW'(N - 1));
    start_ok  = bus.start && (state == IDLE || state == ARMED);
    move_ok   = !bus.start && bus.playerValid && (state == ARMED);
    hit       = (state == CHECK) && mask[idx]
                && ({1'b0, plx} >= {1'b0, cx}) && ({1'b0, plx} < {1'b0, cx} + 9'(COIN_SIZE))
                && ({1'b0, ply} >= {1'b0, cy}) && ({1'b0, ply} < {1'b0, cy} + 8'(COIN_SIZE));
    case (state)
      IDLE:    if (start_ok) state_nxt = DRAW;
      DRAW:    if (pix_last && coin_last) state_nxt = ARMED;
      ARMED:   if (start_ok) state_nxt = DRAW;
               else if (move_ok) state_nxt = CHECK;
      CHECK:   if (hit) state_nxt = ERASE;
               else if (coin_last) state_nxt = ARMED;
      ERASE:   if (pix_last) state_nxt = ARMED;
      default: state_nxt = IDLE;
    endcase
  end

  // Next pixel inside the coin (row-major) and next coin origin, by accumulation.
  always_comb begin
    ox_n = ox + OW'(1);
    oy_n = oy;
    if (ox == OW'(COIN_SIZE - 1)) begin
      ox_n = '0;
      oy_n = oy + OW'(1);
    end
    col_n = col + CW'(1);
    cx_n  = cx + 8'(PITCH);
    cy_n  = cy;
    if (col == CW'(COLS - 1)) begin
      col_n = '0;
      cx_n  = 8'(X0);
      cy_n  = cy + 7'(PITCH);
    end
    mask_after      = mask;
    mask_after[idx] = 1'b0;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      idx <= '0; col <= '0; cx <= '0; cy <= '0; ox <= '0; oy <= '0;
      mask <= '0; plx <= '0; ply <= '0;
      plot_x <= '0; plot_y <= '0; plot_colour <= '0; plot_en <= 1'b0;
      taken <= 1'b0; score_q <= '0; all_done <= 1'b0;
    end else begin
      taken <= 1'b0;
      if (start_ok || move_ok) begin
        idx <= '0; col <= '0; cx <= 8'(X0); cy <= 7'(Y0); ox <= '0; oy <= '0;
      end
      if (start_ok) begin
        mask        <= '1;
        score_q     <= '0;
        all_done    <= 1'b0;
        plot_x      <= 8'(X0);
        plot_y      <= 7'(Y0);
        plot_colour <= COIN_COLOUR;
        plot_en     <= 1'b1;
      end else if (move_ok) begin
        plx <= bus.playerX;
        ply <= bus.playerY;
      end
      case (state)
        DRAW, ERASE: begin
          if (!pix_last) begin
            ox     <= ox_n;
            oy     <= oy_n;
            plot_x <= cx + 8'(ox_n);
            plot_y <= cy + 7'(oy_n);
          end else if (state == DRAW && !coin_last) begin
            idx    <= idx + IW'(1);
            col    <= col_n;
            cx     <= cx_n;
            cy     <= cy_n;
            ox     <= '0;
            oy     <= '0;
            plot_x <= cx_n;
            plot_y <= cy_n;
          end else begin
            plot_en <= 1'b0;
          end
        end
        CHECK: begin
          if (hit) begin
            mask        <= mask_after;
            taken       <= 1'b1;
            if (score_q != {SCORE_W{1'b1}}) score_q <= score_q + SCORE_W'(1);
            if (mask_after == '0) all_done <= 1'b1;
            ox          <= '0;
            oy          <= '0;
            plot_x      <= cx;
            plot_y      <= cy;
            plot_colour <= BG_COLOUR;
            plot_en     <= 1'b1;
          end else if (!coin_last) begin
            idx <= idx + IW'(1);
            col <= col_n;
            cx  <= cx_n;
            cy  <= cy_n;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.oX            = plot_x;
  assign bus.oY            = plot_y;
  assign bus.oColour       = plot_colour;
  assign bus.oPlot         = plot_en;
  assign bus.busy          = (state == DRAW) || (state == CHECK) || (state == ERASE);
  assign bus.coin_taken    = taken;
  assign bus.score         = score_q;
  assign bus.all_collected = all_done;
endmodule

// File: tb/tb_coin_field_drawer.sv
// Directed bench for coin_field_drawer: draw/erase pixel streams, scoring,
// restart, asynchronous reset mid-draw and a 2-bit saturating score instance.
module tb_coin_field_drawer;
  localparam int COLS = 8, ROWS = 6, X0 = 8, Y0 = 8, PITCH = 18;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  coin_field_drawer_if #(.SCORE_W(8)) bus ();
  coin_field_drawer_if #(.SCORE_W(2)) bus_sat ();

  coin_field_drawer dut (.clock(clock), .resetn(resetn), .bus(bus));
  coin_field_drawer #(.SCORE_W(2)) dut_sat (.clock(clock), .resetn(resetn), .bus(bus_sat));

  assign bus_sat.start       = bus.start;
  assign bus_sat.playerX     = bus.playerX;
  assign bus_sat.playerY     = bus.playerY;
  assign bus_sat.playerValid = bus.playerValid;

  typedef struct {
    logic [7:0] x;
    logic [6:0] y;
    logic [8:0] c;
    int         t;
  } plot_t;

  typedef struct {
    int x;
    int y;
    int hit;
    int coin;
    int score;
  } move_t;

  plot_t plots[$];
  int cyc = 0;
  int ct_cnt = 0, ct_cyc = -1, ac_cyc = -1, last_busy_cyc = -1;
  int checks = 0, errors = 0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (bus.oPlot) plots.push_back('{bus.oX, bus.oY, bus.oColour, cyc});
    if (bus.coin_taken) begin
      ct_cnt++;
      ct_cyc = cyc;
    end
    if (bus.all_collected && ac_cyc < 0) ac_cyc = cyc;
    if (bus.busy) last_busy_cyc = cyc;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (bus.busy && n < limit) begin
      tick(1);
      n++;
    end
    if (n >= limit) chk("busy_timeout", n, 0);
  endtask

  task automatic pulse_start(output int d);
    d = cyc;
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
  endtask

  task automatic do_move(input int x, input int y, output int d);
    plots.delete();
    ct_cnt = 0;
    bus.playerX = 8'(x);
    bus.playerY = 7'(y);
    d = cyc;
    bus.playerValid = 1'b1;
    tick(1);
    bus.playerValid = 1'b0;
    wait_idle(200);
    tick(2);
  endtask

  task automatic draw_check(input string tag);
    int d, bad;
    plots.delete();
    pulse_start(d);
    wait_idle(400);
    tick(3);
    chk({tag, "_count"}, plots.size(), ROWS * COLS * 4);
    if (plots.size() == ROWS * COLS * 4) begin
      chk({tag, "_first_cycle"}, plots[0].t, d + 1);
      chk({tag, "_last_cycle"}, plots[191].t, d + 192);
      chk({tag, "_busy_last"}, last_busy_cyc, d + 192);
      chk({tag, "_p1_x"}, plots[1].x, 9);
      chk({tag, "_p2_y"}, plots[2].y, 9);
      chk({tag, "_p41_x"}, plots[40].x, 44);
      chk({tag, "_p44_xy"}, {plots[43].x, 1'b0, plots[43].y}, {8'd45, 1'b0, 7'd27});
      bad = 0;
      for (int k = 0; k < 192; k++) begin
        int coin = k / 4, p = k % 4;
        int ex = X0 + (coin % COLS) * PITCH + p % 2;
        int ey = Y0 + (coin / COLS) * PITCH + p / 2;
        if (plots[k].x != 8'(ex) || plots[k].y != 7'(ey) || plots[k].c != 9'h1F8) bad++;
      end
      chk({tag, "_pixels"}, bad, 0);
    end
  endtask

  move_t moves[10];

  initial begin
    int d, tot, coin_x, coin_y;
    moves[0] = '{45, 27, 1, 10, 1};
    moves[1] = '{45, 27, 0, 0, 1};
    moves[2] = '{30, 30, 0, 0, 1};
    moves[3] = '{8, 8, 1, 0, 2};
    moves[4] = '{9, 9, 0, 0, 2};
    moves[5] = '{135, 99, 1, 47, 3};
    moves[6] = '{136, 98, 0, 0, 3};
    moves[7] = '{134, 97, 0, 0, 3};
    moves[8] = '{62, 45, 1, 19, 4};
    moves[9] = '{7, 8, 0, 0, 4};

    bus.start = 1'b0;
    bus.playerValid = 1'b0;
    bus.playerX = '0;
    bus.playerY = '0;
    tick(3);
    resetn = 1'b1;
    tick(20);
    chk("rst_oPlot", bus.oPlot, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_score", bus.score, 0);
    chk("rst_all", bus.all_collected, 0);

    do_move(8, 8, d);
    chk("idle_move_taken", ct_cnt, 0);
    chk("idle_move_plots", plots.size(), 0);

    draw_check("draw");

    for (int m = 0; m < 10; m++) begin
      do_move(moves[m].x, moves[m].y, d);
      chk($sformatf("mv%0d_taken", m), ct_cnt, moves[m].hit);
      chk($sformatf("mv%0d_plots", m), plots.size(), moves[m].hit * 4);
      chk($sformatf("mv%0d_score", m), bus.score, moves[m].score);
      if (moves[m].hit == 1 && plots.size() == 4) begin
        coin_x = X0 + (moves[m].coin % COLS) * PITCH;
        coin_y = Y0 + (moves[m].coin / COLS) * PITCH;
        chk($sformatf("mv%0d_first_x", m), plots[0].x, coin_x);
        chk($sformatf("mv%0d_first_y", m), plots[0].y, coin_y);
        chk($sformatf("mv%0d_last_xy", m), {plots[3].x, 1'b0, plots[3].y},
            {8'(coin_x + 1), 1'b0, 7'(coin_y + 1)});
        chk($sformatf("mv%0d_colour", m), plots[0].c | plots[3].c, 0);
        chk($sformatf("mv%0d_latency", m), plots[0].t - d, moves[m].coin + 2);
      end
    end

    // Player update arriving mid-erase must be dropped, not queued.
    plots.delete();
    ct_cnt = 0;
    bus.playerX = 8'd27;
    bus.playerY = 7'd9;
    bus.playerValid = 1'b1;
    tick(1);
    bus.playerValid = 1'b0;
    tick(3);
    bus.playerX = 8'd45;
    bus.playerY = 7'd8;
    bus.playerValid = 1'b1;
    tick(1);
    bus.playerValid = 1'b0;
    wait_idle(200);
    tick(60);
    chk("mid_erase_taken", ct_cnt, 1);
    chk("mid_erase_plots", plots.size(), 4);
    chk("mid_erase_score", bus.score, 5);
    chk("sat_score", bus_sat.score, 3);

    tot = 0;
    ac_cyc = -1;
    for (int i = 0; i < ROWS * COLS; i++) begin
      do_move(X0 + (i % COLS) * PITCH, Y0 + (i / COLS) * PITCH, d);
      tot += ct_cnt;
      if (i == 45) chk("all_before_last", bus.all_collected, 0);
    end
    chk("visit_hits", tot, 43);
    chk("visit_score", bus.score, 48);
    chk("visit_all", bus.all_collected, 1);
    chk("all_with_last_take", ac_cyc, ct_cyc);
    chk("sat_score_end", bus_sat.score, 3);

    do_move(8, 8, d);
    chk("after_all_taken", ct_cnt, 0);
    chk("after_all_plots", plots.size(), 0);
    chk("after_all_hold", bus.all_collected, 1);

    pulse_start(d);
    chk("restart_score", bus.score, 0);
    chk("restart_all", bus.all_collected, 0);
    wait_idle(400);
    tick(3);
    draw_check("redraw");

    plots.delete();
    pulse_start(d);
    begin
      int n = 0;
      while (plots.size() < 100 && n < 300) begin
        @(negedge clock);
        n++;
      end
      if (n >= 300) chk("reset_wait_timeout", n, 0);
    end
    #2;
    resetn = 1'b0;
    #1;
    chk("async_rst_oPlot", bus.oPlot, 0);
    chk("async_rst_busy", bus.busy, 0);
    tick(2);
    resetn = 1'b1;
    plots.delete();
    tick(30);
    chk("post_rst_plots", plots.size(), 0);
    chk("post_rst_score", bus.score, 0);
    chk("post_rst_busy", bus.busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
